// File: rtl/fft_frame_writer.sv
// Keeps bins 0..FFT_SIZE/2-1 of each FFT frame, quantises them to pixels and writes them into the
// banked waterfall RAM ring. Define FFT_LOG_SCALE_EN for log2 pixel scaling (default: linear shift).
module fft_frame_writer #(
  parameter int unsigned NO_BANKS       = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 12,
  parameter int unsigned NO_FFTS        = 50,
  parameter int unsigned FFT_SIZE       = 256,
  parameter int unsigned MAG_WIDTH      = 16,
  parameter int unsigned PIX_WIDTH      = 4,
  parameter int unsigned MAG_SHIFT      = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [MAG_WIDTH-1:0]          s_data,
  input  logic                          s_last,
  output logic [NO_BANKS-1:0]           wr_bank_select,
  output logic [RAM_ADDR_WIDTH-1:0]     wr_address,
  output logic [PIX_WIDTH-1:0]          wr_data,
  output logic [$clog2(NO_FFTS)-1:0]    oldest_fft_idx,
  output logic                          frame_done,
  output logic                          frame_err
);

  localparam int unsigned IDX_W   = $clog2(NO_FFTS);
  localparam int unsigned BIN_W   = $clog2(FFT_SIZE);
  localparam int unsigned KEEP_W  = $clog2(FFT_SIZE / 2);
  localparam int unsigned PIX_MAX = (2 ** PIX_WIDTH) - 1;

  localparam logic [BIN_W-1:0] BIN_LAST  = BIN_W'(FFT_SIZE - 1);
  localparam logic [BIN_W-1:0] LAST_KEPT = BIN_W'(FFT_SIZE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NO_FFTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_SKIP, ST_COMMIT} state_e;

  state_e                      state_q, state_d;
  logic [BIN_W-1:0]            bin_cnt_q, bin_cnt_d;
  logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
  logic                        ready_q, ready_d;
  logic [NO_BANKS-1:0]         wr_sel_q, wr_sel_d;
  logic [RAM_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [PIX_WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        xfer_c;
  logic [PIX_WIDTH-1:0]        pix_c;

  assign xfer_c = s_valid & ready_q;

`ifdef FFT_LOG_SCALE_EN
  localparam int unsigned MSB_W = $clog2(MAG_WIDTH);
  logic [MSB_W-1:0] msb_c;

  // Pixel is the position of the leading one, clamped to the pixel range.
  always_comb begin
    msb_c = '0;
    for (int unsigned i = 0; i < MAG_WIDTH; i++) begin
      if (s_data[i]) msb_c = MSB_W'(i);
    end
    pix_c = (32'(msb_c) > PIX_MAX) ? PIX_WIDTH'(PIX_MAX) : PIX_WIDTH'(msb_c);
  end
`else
  logic [MAG_WIDTH-1:0] mag_shift_c;

  // Linear scaling: drop the low MAG_SHIFT bits, then saturate.
  always_comb begin
    mag_shift_c = s_data >> MAG_SHIFT;
    pix_c = (mag_shift_c > MAG_WIDTH'(PIX_MAX)) ? PIX_WIDTH'(PIX_MAX) : PIX_WIDTH'(mag_shift_c);
  end
`endif

  // Frame sequencing: write kept bins, skip the mirror half, commit or abort on the frame end.
  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_sel_d  = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE, ST_SKIP: begin
        if (xfer_c) begin
          if (state_q != ST_SKIP) begin
            wr_sel_d  = NO_BANKS'(1) << wr_idx_q[IDX_W-1];
            wr_addr_d = RAM_ADDR_WIDTH'({wr_idx_q[IDX_W-2:0], bin_cnt_q[KEEP_W-1:0]});
            wr_data_d = pix_c;
          end
          if (bin_cnt_q == BIN_LAST) begin
            bin_cnt_d = '0;
            if (s_last) begin
              state_d = ST_COMMIT;
              done_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            bin_cnt_d = '0;
            state_d   = ST_IDLE;
            err_d     = 1'b1;
          end else begin
            bin_cnt_d = bin_cnt_q + BIN_W'(1);
            state_d   = (bin_cnt_q >= LAST_KEPT) ? ST_SKIP : ST_WRITE;
          end
        end
      end
      ST_COMMIT: begin
        wr_idx_d = (wr_idx_q == IDX_LAST) ? '0 : wr_idx_q + IDX_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_cnt_q <= '0;
      wr_idx_q  <= '0;
      ready_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      wr_idx_q  <= wr_idx_d;
      ready_q   <= ready_d;
      wr_sel_q  <= wr_sel_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // The next slot to be written is the one holding the oldest complete frame.
  assign oldest_fft_idx = wr_idx_q;
  assign s_ready        = ready_q;
  assign wr_bank_select = wr_sel_q;
  assign wr_address     = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign frame_done     = done_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Bench for fft_frame_writer: random and directed frames checked cycle by cycle against a
// transaction-level model of the waterfall ring (honours FFT_LOG_SCALE_EN).
module tb_fft_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [1:0]  wr_bank_select;
  logic [11:0] wr_address;
  logic [3:0]  wr_data;
  logic [5:0]  oldest_fft_idx;
  logic        frame_done;
  logic        frame_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fft_frame_writer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .wr_bank_select (wr_bank_select),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .oldest_fft_idx (oldest_fft_idx),
    .frame_done     (frame_done),
    .frame_err      (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference quantiser written directly from the scaling rules.
  function automatic int ref_pix(input logic [15:0] d);
    int v;
`ifdef FFT_LOG_SCALE_EN
    v = (d == 16'd0) ? 0 : $clog2(int'(d) + 1) - 1;
`else
    v = int'(d) / 4096;
`endif
    return (v > 15) ? 15 : v;
  endfunction

  // Model state: ring slot, bin within frame, and what the next cycle must show.
  bit   exp_rst = 1'b1;
  bit   ready_exp = 1'b0;
  bit   pend_wr = 1'b0, pend_done = 1'b0, pend_err = 1'b0, pend_commit = 1'b0;
  int   pend_bank = 0, pend_addr = 0, pend_pix = 0;
  int   oldest_exp = 0, m_slot = 0, m_bin = 0;
  int   n_wr_obs = 0, n_done_obs = 0, n_err_obs = 0, n_stall_obs = 0;
  int   last_bank_obs = 0, last_addr_obs = 0;
  logic [3:0] obs_pix [128];

  initial begin
    forever begin
      bit xfer;
      @(negedge clk);
      if (wr_bank_select != 2'b00) begin
        n_wr_obs++;
        last_bank_obs = int'(wr_bank_select);
        last_addr_obs = int'(wr_address);
        obs_pix[wr_address[6:0]] = wr_data;
      end
      if (frame_done) n_done_obs++;
      if (frame_err) n_err_obs++;
      if (exp_rst) begin
        check_eq("rst_bank", 32'(wr_bank_select), 0);
        check_eq("rst_addr", 32'(wr_address), 0);
        check_eq("rst_data", 32'(wr_data), 0);
        check_eq("rst_oldest", 32'(oldest_fft_idx), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_err", 32'(frame_err), 0);
        check_eq("rst_ready", 32'(s_ready), 0);
      end else begin
        if (!s_ready) n_stall_obs++;
        check_eq("wr_bank", 32'(wr_bank_select), pend_wr ? pend_bank : 0);
        if (pend_wr) begin
          check_eq("wr_addr", 32'(wr_address), pend_addr);
          check_eq("wr_data", 32'(wr_data), pend_pix);
        end
        check_eq("done", 32'(frame_done), 32'(pend_done));
        check_eq("err", 32'(frame_err), 32'(pend_err));
        check_eq("oldest", 32'(oldest_fft_idx), oldest_exp);
        check_eq("ready", 32'(s_ready), 32'(ready_exp));
      end
      if (!rst_n) begin
        exp_rst = 1'b1; ready_exp = 1'b0;
        pend_wr = 1'b0; pend_done = 1'b0; pend_err = 1'b0; pend_commit = 1'b0;
        oldest_exp = 0; m_slot = 0; m_bin = 0;
      end else begin
        xfer = s_valid && ready_exp && !exp_rst;
        if (pend_commit) oldest_exp = m_slot;
        exp_rst = 1'b0; ready_exp = 1'b1;
        pend_wr = 1'b0; pend_done = 1'b0; pend_err = 1'b0; pend_commit = 1'b0;
        if (xfer) begin
          if (m_bin < 128) begin
            pend_wr   = 1'b1;
            pend_bank = 1 << (m_slot / 32);
            pend_addr = (m_slot % 32) * 128 + m_bin;
            pend_pix  = ref_pix(s_data);
          end
          if (s_last && m_bin == 255) begin
            m_slot = (m_slot + 1) % 50;
            pend_done = 1'b1; pend_commit = 1'b1; ready_exp = 1'b0; m_bin = 0;
          end else if (s_last || m_bin == 255) begin
            pend_err = 1'b1; m_bin = 0;
          end else begin
            m_bin++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && waited < 64) begin @(negedge clk); waited++; end
    check_eq("ready_wait", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  function automatic logic [15:0] beat_data(input int mode, input int i);
    if (mode == 0) return 16'(i * 256);
    if (mode == 2 && i < 4) begin
      case (i)
        0: return 16'h0000;
        1: return 16'h0001;
        2: return 16'h0300;
        default: return 16'hFFFF;
      endcase
    end
    return 16'($urandom);
  endfunction

  // last_at < 0 means no s_last; gap_pct is the chance of idle cycles before a beat.
  task automatic send_frame(input int n_beats, input int last_at, input int gap_pct, input int mode);
    for (int i = 0; i < n_beats; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
      send_beat(beat_data(mode, i), i == last_at);
    end
  endtask

  function automatic int t6_exp(input int k);
`ifdef FFT_LOG_SCALE_EN
    case (k) 0: return 0; 1: return 0; 2: return 9; default: return 15; endcase
`else
    case (k) 0: return 0; 1: return 0; 2: return 0; default: return 15; endcase
`endif
  endfunction

  initial begin
    int w0, d0, e0, s0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Single ramp frame into slot 0.
    w0 = n_wr_obs; d0 = n_done_obs;
    send_frame(256, 255, 0, 0);
    idle(3);
    check_eq("t1_writes", n_wr_obs - w0, 128);
    check_eq("t1_done", n_done_obs - d0, 1);
    check_eq("t1_oldest", 32'(oldest_fft_idx), 1);
    check_eq("t1_last_addr", last_addr_obs, 127);

    // Frames 1..49 around the whole ring.
    d0 = n_done_obs;
    for (int f = 1; f < 50; f++) begin
      send_frame(256, 255, 0, 1);
      if (f == 32) begin
        check_eq("t2_f32_bank", last_bank_obs, 2);
        check_eq("t2_f32_addr", last_addr_obs, 12'h07F);
      end
      if (f == 49) begin
        check_eq("t2_f49_bank", last_bank_obs, 2);
        check_eq("t2_f49_addr", last_addr_obs, 12'h8FF);
      end
    end
    idle(3);
    check_eq("t2_done", n_done_obs - d0, 49);
    check_eq("t2_oldest_wrap", 32'(oldest_fft_idx), 0);

    // Early s_last on beat 100, then a full frame into the same slot.
    d0 = n_done_obs; e0 = n_err_obs;
    send_frame(101, 100, 0, 1);
    idle(3);
    check_eq("t3_err", n_err_obs - e0, 1);
    check_eq("t3_no_done", n_done_obs - d0, 0);
    check_eq("t3_oldest", 32'(oldest_fft_idx), 0);
    send_frame(256, 255, 0, 1);
    idle(3);
    check_eq("t3_reuse_bank", last_bank_obs, 1);
    check_eq("t3_reuse_addr", last_addr_obs, 12'h07F);
    check_eq("t3_oldest_after", 32'(oldest_fft_idx), 1);

    // Missing s_last at the final bin.
    d0 = n_done_obs; e0 = n_err_obs;
    send_frame(256, -1, 0, 1);
    idle(3);
    check_eq("tm_err", n_err_obs - e0, 1);
    check_eq("tm_no_done", n_done_obs - d0, 0);
    check_eq("tm_oldest", 32'(oldest_fft_idx), 1);

    // Random valid gaps.
    w0 = n_wr_obs; d0 = n_done_obs;
    send_frame(256, 255, 50, 1);
    idle(3);
    check_eq("t4_writes", n_wr_obs - w0, 128);
    check_eq("t4_done", n_done_obs - d0, 1);
    check_eq("t4_oldest", 32'(oldest_fft_idx), 2);

    // Back-to-back frames with s_valid held across boundaries.
    w0 = n_wr_obs; d0 = n_done_obs; s0 = n_stall_obs;
    for (int f = 0; f < 3; f++) send_frame(256, 255, 0, 1);
    idle(3);
    check_eq("t5_writes", n_wr_obs - w0, 384);
    check_eq("t5_done", n_done_obs - d0, 3);
    check_eq("t5_stalls", n_stall_obs - s0, 3);
    check_eq("t5_oldest", 32'(oldest_fft_idx), 5);

    // Quantiser corner values on bins 0..3.
    send_frame(256, 255, 0, 2);
    idle(3);
    for (int k = 0; k < 4; k++) check_eq("t6_pix", 32'(obs_pix[k]), t6_exp(k));

    // Reset in the middle of a frame.
    send_frame(60, -1, 0, 1);
    s_valid = 1'b1; s_data = 16'h1234; rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("t7_rst_ready", 32'(s_ready), 0);
    check_eq("t7_rst_oldest", 32'(oldest_fft_idx), 0);
    rst_n = 1'b1;
    idle(2);
    send_frame(256, 255, 0, 1);
    idle(3);
    check_eq("t7_bank", last_bank_obs, 1);
    check_eq("t7_addr", last_addr_obs, 12'h07F);
    check_eq("t7_oldest", 32'(oldest_fft_idx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    repeat (80000) @(posedge clk);
    n_mis++;
    $display("FAIL watchdog: cycle budget expired, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
